irq_resp: RTL and testbench

IRQ_RESP -- requirements
Module: irq_resp

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_resp_if.sv | 44 ++++
 rtl/irq_lat_cnt.sv | 32 +++
 rtl/irq_resp.sv | 121 ++++++++++++
 tb/tb_irq_resp.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt response controller.
package irq_pkg;

   localparam int DW_DEF       = 32;
   localparam int IACK_LEN_DEF = 1;

   // Response sequencer states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BND = 3'd1,
      ACK      = 3'd2,
      ISR      = 3'd3,
      RET      = 3'd4
   } irq_state_e;

   // 16-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

endpackage

// File: rtl/irq_resp_if.sv
// Core-side bundle of the interrupt responder.
// Optional statistics outputs exist only when IRQ_RESP_LAT_EN is defined.
interface irq_resp_if
   import irq_pkg::*;
#(
   parameter int DW = DW_DEF
);

   logic          irq;
   logic [DW-1:0] PC_handler;
   logic          ie;
   logic          retire;
   logic [DW-1:0] pc_ret;
   logic          eret;

   logic          iack;
   logic          redirect;
   logic [DW-1:0] redirect_pc;
   logic [DW-1:0] epc;
   logic          in_isr;
`ifdef IRQ_RESP_LAT_EN
   logic [15:0]   lat_max;
   logic [15:0]   irq_cnt;
`endif

   // Core / interrupt controller side
   modport master (
      output irq, PC_handler, ie, retire, pc_ret, eret,
`ifdef IRQ_RESP_LAT_EN
      input  lat_max, irq_cnt,
`endif
      input  iack, redirect, redirect_pc, epc, in_isr
   );

   // Responder side
   modport slave (
      input  irq, PC_handler, ie, retire, pc_ret, eret,
`ifdef IRQ_RESP_LAT_EN
      output lat_max, irq_cnt,
`endif
      output iack, redirect, redirect_pc, epc, in_isr
   );

endinterface

// File: rtl/irq_lat_cnt.sv
// Interrupt entry latency and serviced-count statistics.
// Built only when IRQ_RESP_LAT_EN is defined.
module irq_lat_cnt
   import irq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_wait,
   input  logic        ack_start,
   output logic [15:0] lat_max,
   output logic [15:0] irq_cnt
);

   logic [15:0] lat_cur;

   // Count cycles spent waiting for a boundary; fold into max on the ACK redirect
   always_ff @(posedge clk) begin
      if (!rst) begin
         lat_cur <= '0;
         lat_max <= '0;
         irq_cnt <= '0;
      end else begin
         if (in_wait) lat_cur <= sat_inc16(lat_cur);
         else         lat_cur <= '0;
         if (ack_start) begin
            if (lat_cur > lat_max) lat_max <= lat_cur;
            irq_cnt <= sat_inc16(irq_cnt);
         end
      end
   end

endmodule

// File: rtl/irq_resp.sv
// Interrupt response sequencer: waits for an instruction boundary, saves the
// return PC, redirects to the handler with an acknowledge pulse, and redirects
// back on eret. Define IRQ_RESP_LAT_EN to add the latency/count statistics.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no interrupt in progress, sampling irq & ie
// WAIT_BND | request accepted, waiting for a retire boundary (or irq drop)
// ACK      | iack pulse train; handler redirect on the first cycle only
// ISR      | handler running, irq/ie ignored, waiting for eret
// RET      | one-cycle redirect back to epc
module irq_resp
   import irq_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int IACK_LEN = IACK_LEN_DEF
)(
   input  logic      clk,
   input  logic      rst,
   irq_resp_if.slave bus
);

   localparam int             CW       = $clog2(IACK_LEN + 1);
   localparam logic [CW-1:0]  ACK_LOAD = CW'(IACK_LEN);
   localparam logic [CW-1:0]  ACK_LAST = CW'(1);

   irq_state_e    state, state_nxt;
   logic [CW-1:0] ack_cnt, ack_cnt_nxt;
   logic [DW-1:0] vec, epc_q;
   logic          capture;
   logic          iack, redirect, in_isr, ack_first;
   logic [DW-1:0] redirect_pc;

   // State, iack down-counter and captured handler/return addresses
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         ack_cnt <= '0;
         vec     <= '0;
         epc_q   <= '0;
      end else begin
         state   <= state_nxt;
         ack_cnt <= ack_cnt_nxt;
         if (capture) begin
            epc_q <= bus.pc_ret;
            vec   <= bus.PC_handler;
         end
      end
   end

   // Next-state decode and Moore outputs
   always_comb begin
      state_nxt   = state;
      ack_cnt_nxt = ack_cnt;
      capture     = 1'b0;
      iack        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      in_isr      = 1'b0;
      ack_first   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.irq && bus.ie) state_nxt = WAIT_BND;
         end
         WAIT_BND: begin
            // A dropped request abandons the sequence even on a boundary
            if (!bus.irq) begin
               state_nxt = IDLE;
            end else if (bus.retire) begin
               capture     = 1'b1;
               ack_cnt_nxt = ACK_LOAD;
               state_nxt   = ACK;
            end
         end
         ACK: begin
            iack      = 1'b1;
            ack_first = (ack_cnt == ACK_LOAD);
            redirect  = ack_first;
            if (ack_first) redirect_pc = vec;
            // Terminal count also covers zero so the counter can never wrap
            if (ack_cnt <= ACK_LAST) begin
               ack_cnt_nxt = '0;
               state_nxt   = ISR;
            end else begin
               ack_cnt_nxt = ack_cnt - ACK_LAST;
            end
         end
         ISR: begin
            in_isr = 1'b1;
            if (bus.eret) state_nxt = RET;
         end
         RET: begin
            redirect    = 1'b1;
            redirect_pc = epc_q;
            in_isr      = 1'b1;
            state_nxt   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.iack        = iack;
   assign bus.redirect    = redirect;
   assign bus.redirect_pc = redirect_pc;
   assign bus.epc         = epc_q;
   assign bus.in_isr      = in_isr;

`ifdef IRQ_RESP_LAT_EN
   irq_lat_cnt u_lat (
      .clk       (clk),
      .rst       (rst),
      .in_wait   (state == WAIT_BND),
      .ack_start (ack_first),
      .lat_max   (bus.lat_max),
      .irq_cnt   (bus.irq_cnt)
   );
`endif

endmodule

// File: tb/tb_irq_resp.sv
// Scoreboard bench for irq_resp: the driver issues whole interrupt episodes
// and queues the expected output cycles; a monitor compares every cycle in
// which the responder shows iack, redirect or in_isr.
module tb_irq_resp;
   import irq_pkg::*;

   localparam int DW       = 32;
   localparam int IACK_LEN = 3;

   typedef struct {
      int            cyc;
      logic          iack;
      logic          redirect;
      logic          in_isr;
      logic [DW-1:0] rpc;
      logic [DW-1:0] epc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;
   ev_t  exp_q[$];
   int   svc_cnt = 0;
   int   lat_mx = 0;

   irq_resp_if #(.DW(DW)) bus ();

   irq_resp #(.DW(DW), .IACK_LEN(IACK_LEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input logic ia, input logic rd, input logic ii,
                       input logic [DW-1:0] rpc, input logic [DW-1:0] epc);
      ev_t e;
      e.cyc = c; e.iack = ia; e.redirect = rd; e.in_isr = ii; e.rpc = rpc; e.epc = epc;
      exp_q.push_back(e);
   endtask

   task automatic noise();
      bus.irq        = 1'($urandom);
      bus.ie         = 1'($urandom);
      bus.retire     = 1'($urandom);
      bus.pc_ret     = DW'($urandom);
      bus.PC_handler = DW'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         noise();
         bus.irq  = 1'b0;
         bus.eret = 1'($urandom);
      end
   endtask

   // One episode from IDLE: request, d boundary-less cycles, then either a
   // drop or a retire, handler lasting s+1 cycles, eret, return redirect.
   task automatic service(input int d, input int s, input bit drop, input bit drop_ret,
                          input logic [DW-1:0] h, input logic [DW-1:0] p);
      int k, a, isr0;
      @(negedge clk);
      k = cyc;
      bus.irq = 1'b1; bus.ie = 1'b1; bus.PC_handler = h;
      bus.retire = 1'($urandom); bus.eret = 1'($urandom); bus.pc_ret = DW'($urandom);
      repeat (d) begin
         @(negedge clk);
         bus.irq = 1'b1; bus.ie = 1'b1; bus.retire = 1'b0;
         bus.eret = 1'($urandom); bus.pc_ret = DW'($urandom);
      end
      @(negedge clk);
      if (drop) begin
         bus.irq = 1'b0; bus.retire = drop_ret; bus.eret = 1'($urandom);
         return;
      end
      bus.irq = 1'b1; bus.retire = 1'b1; bus.pc_ret = p;
      a = k + 2 + d;
      svc_cnt++;
      if (d + 1 > lat_mx) lat_mx = d + 1;
      for (int j = 0; j < IACK_LEN; j++)
         push(a + j, 1'b1, (j == 0), 1'b0, (j == 0) ? h : '0, p);
      isr0 = a + IACK_LEN;
      for (int j = 0; j <= s; j++) push(isr0 + j, 1'b0, 1'b0, 1'b1, '0, p);
      push(isr0 + s + 1, 1'b0, 1'b1, 1'b1, p, p);
      repeat (IACK_LEN) begin @(negedge clk); noise(); bus.eret = 1'($urandom); end
      repeat (s) begin @(negedge clk); noise(); bus.eret = 1'b0; end
      @(negedge clk); noise(); bus.eret = 1'b1;
      @(negedge clk); noise(); bus.eret = 1'($urandom);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_iack"}, 64'(bus.iack), 64'd0);
      chk({tag, "_redirect"}, 64'(bus.redirect), 64'd0);
      chk({tag, "_redirect_pc"}, 64'(bus.redirect_pc), 64'd0);
      chk({tag, "_epc"}, 64'(bus.epc), 64'd0);
      chk({tag, "_in_isr"}, 64'(bus.in_isr), 64'd0);
   endtask

   // Monitor: pop one expectation per active output cycle
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (bus.iack || bus.redirect || bus.in_isr) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_out cyc=%0d iack=%b redirect=%b in_isr=%b exp=none",
                           cyc, bus.iack, bus.redirect, bus.in_isr);
               end else begin
                  e = exp_q.pop_front();
                  chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                  chk("ev_iack", 64'(bus.iack), 64'(e.iack));
                  chk("ev_redirect", 64'(bus.redirect), 64'(e.redirect));
                  chk("ev_in_isr", 64'(bus.in_isr), 64'(e.in_isr));
                  chk("ev_redirect_pc", 64'(bus.redirect_pc), 64'(e.rpc));
                  chk("ev_epc", 64'(bus.epc), 64'(e.epc));
               end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               checks++; errors++;
               $display("FAIL missing_out cyc=%0d got=quiet exp_cyc=%0d", cyc, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
            if (!bus.redirect) chk("rpc_zero_when_idle", 64'(bus.redirect_pc), 64'd0);
         end
      end
   end

   initial begin
      int t;
      logic [DW-1:0] h, p;
      bus.irq = 1'b1; bus.ie = 1'b1; bus.retire = 1'b1; bus.eret = 1'b1;
      bus.PC_handler = 32'h200; bus.pc_ret = 32'h300;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      bus.irq = 1'b0; bus.retire = 1'b0; bus.eret = 1'b0;
      rst = 1'b1;
      mon_on = 1'b1;
      idle_cycles(2);

      // Handler 0x100, return 0x44, retire right after the request
      service(0, 2, 1'b0, 1'b0, 32'h100, 32'h44);
      idle_cycles(1);
      // Spurious requests: drop without and with a coincident retire
      service(2, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      service(0, 0, 1'b1, 1'b1, 32'h0, 32'h0);
      idle_cycles(2);

      for (int n = 0; n < 40; n++) begin
         h = DW'($urandom); p = DW'($urandom);
         service(int'($urandom_range(6)), int'($urandom_range(4)),
                 ($urandom_range(3) == 0), 1'($urandom), h, p);
         if ($urandom_range(1) == 1) idle_cycles(int'($urandom_range(3)));
      end

      // Reset in the middle of the iack train
      @(negedge clk);
      bus.irq = 1'b1; bus.ie = 1'b1; bus.PC_handler = 32'hABC0; bus.retire = 1'b0; bus.eret = 1'b0;
      @(negedge clk);
      bus.retire = 1'b1; bus.pc_ret = 32'h5550;
      push(cyc + 1, 1'b1, 1'b1, 1'b0, 32'hABC0, 32'h5550);
      @(negedge clk);
      rst = 1'b0; bus.irq = 1'b0; bus.retire = 1'b0;
      @(negedge clk);
      chk_quiet("mid_ack_reset");
      rst = 1'b1;
      svc_cnt = 0; lat_mx = 0;

      // Masked requests get no response
      repeat (6) begin
         @(negedge clk);
         noise();
         bus.irq = 1'b1; bus.ie = 1'b0; bus.eret = 1'($urandom);
      end

      // Two services with a 5-cycle boundary wait
      service(5, 1, 1'b0, 1'b0, 32'h1000, 32'h2000);
      idle_cycles(1);
      service(5, 0, 1'b0, 1'b0, 32'h1100, 32'h2100);
      idle_cycles(3);

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
      end

`ifdef IRQ_RESP_LAT_EN
      chk("lat_max", 64'(bus.lat_max), 64'(lat_mx));
      chk("irq_cnt", 64'(bus.irq_cnt), 64'(svc_cnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
